// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter:
// FSM encoding, watchdog counter width and the round-robin pick function.
package wb_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t GNT0 = 2'd1;
    localparam arb_state_t GNT1 = 2'd2;

    localparam int TO_CNT_W = 16;

    // i_last: 0 = m0 held the bus last, 1 = m1 did; a tie goes to the other one
    function automatic arb_state_t arb_pick(input logic i_cyc0, input logic i_cyc1,
                                            input logic i_last);
        if (i_cyc0 && i_cyc1) return i_last ? GNT0 : GNT1;
        if (i_cyc0)           return GNT0;
        if (i_cyc1)           return GNT1;
        return IDLE;
    endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Bus watchdog: counts stalled strobe cycles and fires a one-cycle error
// pulse when the slave has not answered within TIMEOUT_CYCLES.
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_stb_req,
    input  logic i_ack,
    input  logic i_err,
    input  logic i_gnt_chg,
    output logic o_to_err
);

    localparam logic [TO_CNT_W-1:0] LIMIT  = TO_CNT_W'(TIMEOUT_CYCLES);
    localparam logic                ENABLE = (TIMEOUT_CYCLES != 0);

    logic [TO_CNT_W-1:0] r_cnt;
    logic                w_stall;

    // A slave ack in the limit cycle wins over the watchdog
    assign o_to_err = ENABLE && i_stb_req && !i_ack && (r_cnt == LIMIT);
    assign w_stall  = i_stb_req && !o_to_err && !i_ack && !i_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_gnt_chg || !w_stall) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter2.sv
// Two-master, one-slave Wishbone B3 classic arbiter with round-robin
// priority; a grant is held for the whole cycle so bursts stay atomic.
module wb_rr_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    output logic [1:0]      grant_o
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_req_stb;
    logic       w_to_err;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == GNT0)      r_last <= 1'b0;
            else if (w_state_nxt == GNT1) r_last <= 1'b1;
        end
    end

    // Re-arbitrate straight out of a grant so a waiting master loses no cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            GNT0:    if (!m0_cyc_i) w_state_nxt = arb_pick(m0_cyc_i, m1_cyc_i, r_last);
            GNT1:    if (!m1_cyc_i) w_state_nxt = arb_pick(m0_cyc_i, m1_cyc_i, r_last);
            default: w_state_nxt = arb_pick(m0_cyc_i, m1_cyc_i, r_last);
        endcase
    end

    assign w_gnt0    = (r_state == GNT0);
    assign w_gnt1    = (r_state == GNT1);
    assign w_req_stb = (w_gnt0 && m0_stb_i) || (w_gnt1 && m1_stb_i);

    wb_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (wb_clk_i),
        .i_rst    (wb_rst_i),
        .i_stb_req(w_req_stb),
        .i_ack    (s_ack_i),
        .i_err    (s_err_i),
        .i_gnt_chg(r_state != w_state_nxt),
        .o_to_err (w_to_err)
    );

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (r_state)
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | w_to_err;
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | w_to_err;
            end
            default: ;
        endcase
    end

    assign s_stb_o  = w_req_stb && !w_to_err;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant_o  = {w_gnt1, w_gnt0};

endmodule

// File: tb/tb_wb_rr_arbiter2.sv
// Bench for wb_rr_arbiter2: directed scenarios plus random traffic, all
// checked every cycle against an owner/preference/stall-count model.
module tb_wb_rr_arbiter2;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_adr [2];
    logic [31:0] m_wd  [2];
    logic [3:0]  m_sel [2];
    logic        m_we  [2];
    logic        m_cyc [2];
    logic        m_stb [2];
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic [1:0]  grant_o;

    int errors = 0;
    int checks = 0;

    // model: owner 0 = nobody, 1 = m0, 2 = m1; last_m = most recent owner
    int   owner, last_m, stalls;
    logic e_sstb;

    always #5 clk = ~clk;

    wb_rr_arbiter2 #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i(clk),       .wb_rst_i(rst),
        .m0_adr_i(m_adr[0]),  .m0_dat_i(m_wd[0]),  .m0_sel_i(m_sel[0]),
        .m0_we_i (m_we[0]),   .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
        .m0_dat_o(m0_dat_o),  .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m_adr[1]),  .m1_dat_i(m_wd[1]),  .m1_sel_i(m_sel[1]),
        .m1_we_i (m_we[1]),   .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
        .m1_dat_o(m1_dat_o),  .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o (s_adr_o),   .s_dat_o (s_dat_o),  .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),    .s_cyc_o (s_cyc_o),  .s_stb_o (s_stb_o),
        .s_dat_i (s_dat_i),   .s_ack_i (s_ack_i),  .s_err_i (s_err_i),
        .grant_o (grant_o)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge once inputs are applied; checks all outputs.
    task automatic eval();
        logic [1:0]  eg;
        logic [31:0] ea, ed;
        logic [3:0]  es;
        logic        ew, ec, rs, to;
        #1;
        eg = 2'b00; ea = '0; ed = '0; es = '0; ew = 1'b0; ec = 1'b0; rs = 1'b0;
        if (owner != 0) begin
            eg = (owner == 1) ? 2'b01 : 2'b10;
            ea = m_adr[owner-1];
            ed = m_wd[owner-1];
            es = m_sel[owner-1];
            ew = m_we[owner-1];
            ec = m_cyc[owner-1];
            rs = m_stb[owner-1];
        end
        to     = (TO != 0) && (stalls == TO) && rs && !s_ack_i;
        e_sstb = rs && !to;
        chkv("grant",  32'(grant_o), 32'(eg));
        chk1("s_cyc",  s_cyc_o, ec);
        chk1("s_stb",  s_stb_o, e_sstb);
        chkv("s_adr",  s_adr_o, ea);
        chkv("s_dat",  s_dat_o, ed);
        chkv("s_sel",  32'(s_sel_o), 32'(es));
        chk1("s_we",   s_we_o, ew);
        chk1("m0_ack", m0_ack_o, (owner == 1) && s_ack_i);
        chk1("m0_err", m0_err_o, (owner == 1) && (s_err_i || to));
        chk1("m1_ack", m1_ack_o, (owner == 2) && s_ack_i);
        chk1("m1_err", m1_err_o, (owner == 2) && (s_err_i || to));
        chkv("m0_dat", m0_dat_o, s_dat_i);
        chkv("m1_dat", m1_dat_o, s_dat_i);
    endtask

    // Advance the model across one rising edge, return at the next falling edge.
    task automatic adv();
        int nxt;
        @(posedge clk);
        if (owner != 0 && m_cyc[owner-1]) nxt = owner;
        else if (m_cyc[0] && m_cyc[1])    nxt = (last_m == 1) ? 2 : 1;
        else if (m_cyc[0])                nxt = 1;
        else if (m_cyc[1])                nxt = 2;
        else                              nxt = 0;
        if (nxt != owner || !(e_sstb && !s_ack_i && !s_err_i)) stalls = 0;
        else if (stalls < 65535)                              stalls++;
        owner = nxt;
        if (nxt != 0) last_m = nxt;
        @(negedge clk);
    endtask

    task automatic tick();
        eval();
        adv();
    endtask

    task automatic req(input int j, input logic on);
        m_cyc[j] = on;
        m_stb[j] = on;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "bench time limit");
    end

    initial begin
        int acks[$];
        logic acked [2];

        for (int j = 0; j < 2; j++) begin
            m_adr[j] = 32'h1000 * (j + 1); m_wd[j] = 32'hA000 + j;
            m_sel[j] = 4'hF; m_we[j] = 1'b0; req(j, 1'b1);
        end
        s_dat_i = 32'h0; s_ack_i = 1'b1; s_err_i = 1'b1;
        rst = 1'b1;
        owner = 0; last_m = 2; stalls = 0;

        // reset state while masters and slave are all active
        @(negedge clk); #1;
        chkv("rst_grant", 32'(grant_o), 32'h0);
        chk1("rst_s_cyc", s_cyc_o, 1'b0);
        chk1("rst_s_stb", s_stb_o, 1'b0);
        chk1("rst_m0_ack", m0_ack_o, 1'b0);
        chk1("rst_m0_err", m0_err_o, 1'b0);
        chk1("rst_m1_ack", m1_ack_o, 1'b0);
        chk1("rst_m1_err", m1_err_o, 1'b0);
        chkv("rst_s_adr", s_adr_o, 32'h0);
        @(negedge clk);
        s_ack_i = 1'b0; s_err_i = 1'b0;
        rst = 1'b0;

        // both request straight after reset: m0 first, then m1 with no idle gap
        tick();
        eval(); chkv("first_gnt", 32'(grant_o), 32'h1); adv();
        s_ack_i = 1'b1; tick();
        req(0, 1'b0); s_ack_i = 1'b0;
        eval(); adv();
        eval(); chkv("handoff_gnt", 32'(grant_o), 32'h2); chk1("handoff_cyc", s_cyc_o, 1'b1); adv();
        s_ack_i = 1'b1; tick();
        req(1, 1'b0); s_ack_i = 1'b0; tick(); tick();

        // m0 single read
        req(0, 1'b1); m_adr[0] = 32'h100;
        eval(); chkv("rd_idle_gnt", 32'(grant_o), 32'h0); chk1("rd_idle_cyc", s_cyc_o, 1'b0); adv();
        eval(); chkv("rd_gnt", 32'(grant_o), 32'h1); chk1("rd_cyc", s_cyc_o, 1'b1); adv();
        s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
        eval();
        chk1("rd_m0_ack", m0_ack_o, 1'b1);
        chkv("rd_m0_dat", m0_dat_o, 32'hDEADBEEF);
        chk1("rd_m1_ack", m1_ack_o, 1'b0);
        adv();
        req(0, 1'b0); s_ack_i = 1'b0; tick(); tick();

        // continuous single-beat traffic from both: m0 was last, so m1 leads
        acked[0] = 1'b0; acked[1] = 1'b0;
        for (int c = 0; c < 40 && acks.size() < 8; c++) begin
            for (int j = 0; j < 2; j++) req(j, !acked[j]);
            s_ack_i = (owner == 0) ? 1'b0 : m_cyc[owner-1];
            eval();
            acked[0] = s_ack_i && (owner == 1);
            acked[1] = s_ack_i && (owner == 2);
            if (m0_ack_o) acks.push_back(1);
            if (m1_ack_o) acks.push_back(2);
            adv();
        end
        chkv("alt_count", 32'(acks.size()), 32'd8);
        for (int i = 0; i < acks.size(); i++)
            chkv("alt_seq", 32'(acks[i]), (i % 2 == 0) ? 32'd2 : 32'd1);
        req(0, 1'b0); req(1, 1'b0); s_ack_i = 1'b0; tick(); tick();

        // m1 4-beat burst is not pre-empted by a waiting m0
        req(1, 1'b1); tick();
        req(0, 1'b1); s_ack_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            eval();
            chkv("burst_gnt", 32'(grant_o), 32'h2);
            chk1("burst_m1_ack", m1_ack_o, 1'b1);
            chk1("burst_m0_ack", m0_ack_o, 1'b0);
            adv();
        end
        req(1, 1'b0); s_ack_i = 1'b0;
        eval(); adv();
        eval(); chkv("burst_handoff", 32'(grant_o), 32'h1); adv();
        s_ack_i = 1'b1; tick();
        req(0, 1'b0); s_ack_i = 1'b0; tick(); tick();

        // watchdog: 8 stalled strobes, one error cycle, restart, then ack beats the limit
        req(0, 1'b1); tick();
        for (int k = 0; k < TO; k++) begin
            eval();
            chk1("to_stall_stb", s_stb_o, 1'b1);
            chk1("to_stall_err", m0_err_o, 1'b0);
            adv();
        end
        eval(); chk1("to_err", m0_err_o, 1'b1); chk1("to_stb_low", s_stb_o, 1'b0); adv();
        eval(); chk1("to_restart", s_stb_o, 1'b1); chk1("to_restart_err", m0_err_o, 1'b0); adv();
        for (int k = 0; k < TO - 1; k++) tick();
        s_ack_i = 1'b1;
        eval();
        chk1("to_ack_wins_ack", m0_ack_o, 1'b1);
        chk1("to_ack_wins_err", m0_err_o, 1'b0);
        chk1("to_ack_wins_stb", s_stb_o, 1'b1);
        adv();
        req(0, 1'b0); s_ack_i = 1'b0; tick(); tick();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < 2; j++) begin
                m_cyc[j] = m_cyc[j] ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
                m_stb[j] = m_cyc[j] && ($urandom_range(0, 3) != 0);
                m_adr[j] = $urandom; m_wd[j] = $urandom;
                m_sel[j] = 4'($urandom); m_we[j] = 1'($urandom);
            end
            s_ack_i = ($urandom_range(0, 2) == 0);
            s_err_i = ($urandom_range(0, 9) == 0);
            s_dat_i = $urandom;
            tick();
        end
        req(0, 1'b0); req(1, 1'b0); s_ack_i = 1'b0; s_err_i = 1'b0; tick(); tick();

        // asynchronous reset in the middle of an m1 burst
        req(1, 1'b1); tick();
        s_ack_i = 1'b1; tick();
        req(0, 1'b1);
        #3;
        s_err_i = 1'b1;
        rst = 1'b1;
        #1;
        chkv("arst_grant", 32'(grant_o), 32'h0);
        chk1("arst_s_cyc", s_cyc_o, 1'b0);
        chk1("arst_s_stb", s_stb_o, 1'b0);
        chk1("arst_m0_ack", m0_ack_o, 1'b0);
        chk1("arst_m1_ack", m1_ack_o, 1'b0);
        chk1("arst_m0_err", m0_err_o, 1'b0);
        chk1("arst_m1_err", m1_err_o, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0;
        owner = 0; last_m = 2; stalls = 0;
        eval(); adv();
        eval(); chkv("post_rst_gnt", 32'(grant_o), 32'h1); adv();
        req(0, 1'b0); req(1, 1'b0); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
